// File: rtl/alu_op_pkg.sv
// Operation codes and helpers shared by the execute-stage ALU and the ALU controller.
// Codes that are not listed here still decode. They produce a zero result in one cycle.
package alu_op_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_XOR = 4'b0010,
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0101,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_BLT = 4'b1010,
        OP_BGE = 4'b1011,
        OP_SLL = 4'b1100,
        OP_SRL = 4'b1101,
        OP_SRA = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        SHIFT_LL = 2'd0,
        SHIFT_RL = 2'd1,
        SHIFT_RA = 2'd2
    } shift_kind_e;

    function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic shift_kind_e shift_kind(input logic [ALU_OP_W-1:0] op);
        case (op)
            OP_SRL:  return SHIFT_RL;
            OP_SRA:  return SHIFT_RA;
            default: return SHIFT_LL;
        endcase
    endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Valid/ready operand and result bundle between the execute stage and the iterative ALU.
// The execute stage is the master. The ALU is the slave.
interface iterative_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shifter. It loads an operand, a shift amount and a shift kind on start_i.
// It raises done_o during the final shift cycle, and result_o then holds the fully shifted value.
module alu_iter_shifter
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  shift_kind_e           kind_i,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
    shift_kind_e           kind_q, kind_d;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shifted = value_q;
        case (kind_q)
            SHIFT_LL: shifted = {value_q[DATA_WIDTH-2:0], 1'b0};
            SHIFT_RL: shifted = {1'b0, value_q[DATA_WIDTH-1:1]};
            SHIFT_RA: shifted = {value_q[DATA_WIDTH-1], value_q[DATA_WIDTH-1:1]};
            default:  shifted = value_q;
        endcase
    end

    // A non-zero counter means a shift is in flight. Each cycle consumes one bit position.
    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        if (start_i) begin
            value_d = value_i;
            cnt_d   = shamt_i;
            kind_d  = kind_i;
        end else if (cnt_q != '0) begin
            value_d = shifted;
            cnt_d   = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            value_q <= '0;
            cnt_q   <= '0;
            kind_q  <= SHIFT_LL;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

    assign done_o   = (cnt_q == SHAMT_W'(1));
    assign result_o = shifted;

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU. Logic, arithmetic and compare operations finish in a single cycle.
// Shifts go through a serial shifter. The result register is guarded by a valid/ready handshake.
module iterative_alu
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    iterative_alu_if.slave bus
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;

    logic                  accept;
    logic                  shift_start;
    logic                  shift_done;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] comb_result;
    logic [DATA_WIDTH-1:0] shift_result;
    alu_op_e               op;

    assign op       = alu_op_e'(bus.Operation);
    assign shamt    = bus.SrcB[SHAMT_W-1:0];
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);

    // Single-cycle datapath. A shift only reaches this path when the amount is zero.
    always_comb begin
        comb_result = '0;
        case (op)
            OP_AND:  comb_result = bus.SrcA & bus.SrcB;
            OP_OR:   comb_result = bus.SrcA | bus.SrcB;
            OP_XOR:  comb_result = bus.SrcA ^ bus.SrcB;
            OP_ADD:  comb_result = bus.SrcA + bus.SrcB;
            OP_SUB:  comb_result = bus.SrcA - bus.SrcB;
            OP_BEQ:  comb_result = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA == bus.SrcB};
            OP_BNE:  comb_result = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA != bus.SrcB};
            OP_BLT:  comb_result = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.SrcA) <  $signed(bus.SrcB)};
            OP_BGE:  comb_result = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.SrcA) >= $signed(bus.SrcB)};
            OP_SLL, OP_SRL, OP_SRA: comb_result = bus.SrcA;
            default: comb_result = '0;
        endcase
    end

    alu_iter_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (shift_start),
        .kind_i   (shift_kind(bus.Operation)),
        .value_i  (bus.SrcA),
        .shamt_i  (shamt),
        .done_o   (shift_done),
        .result_o (shift_result)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        shift_start = 1'b0;

        // A drain clears valid. An accept in the same cycle sets it again.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift(bus.Operation) && (shamt != '0)) begin
                        shift_start = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        result_d    = comb_result;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    result_d    = shift_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu. Fixed scenarios plus a randomized sequence.
// All expected values come from an arithmetic reference model.
module tb_iterative_alu;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    iterative_alu_if #(.DATA_WIDTH(DW)) bus ();

    iterative_alu #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operation code.
    function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'b0000: model = a & b;
            4'b0001: model = a | b;
            4'b0010: model = a ^ b;
            4'b0100: model = a + b;
            4'b0101: model = a - b;
            4'b1000: model = DW'(a == b);
            4'b1001: model = DW'(a != b);
            4'b1010: model = DW'($signed(a) < $signed(b));
            4'b1011: model = DW'($signed(a) >= $signed(b));
            4'b1100: model = a << s;
            4'b1101: model = a >> s;
            4'b1110: model = DW'($signed(a) >>> s);
            default: model = '0;
        endcase
    endfunction

    // Falling edges after the accept edge until out_valid is seen.
    // A shift by s > 0 completes s edges after the accept edge.
    function automatic int exp_edges(input logic [3:0] op, input logic [DW-1:0] b);
        if ((op == 4'b1100 || op == 4'b1101 || op == 4'b1110) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Called at a falling edge. Returns just after the rising edge that accepts the operation.
    task automatic accept_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input string name);
        int guard = 0;
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        #1;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1 within 200 cycles", name, bus.in_ready);
        end
        @(posedge clk);
    endtask

    task automatic wait_result(output int edges, output int low_ready);
        edges     = 0;
        low_ready = 0;
        do begin
            @(negedge clk);
            if (edges == 0) bus.in_valid = 1'b0;
            edges++;
            if (bus.out_valid !== 1'b1 && bus.in_ready === 1'b0) low_ready++;
        end while (bus.out_valid !== 1'b1 && edges < 100);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int stall, input string name);
        logic [DW-1:0] exp;
        int            edges, low;
        logic          held_ok;
        exp = model(op, a, b);
        @(negedge clk);
        bus.out_ready = (stall == 0);
        accept_op(op, a, b, name);
        wait_result(edges, low);
        checks++;
        if (edges != exp_edges(op, b)) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, edges, exp_edges(op, b));
        end
        checks++;
        if (bus.ALUResult !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, required %h", name, bus.ALUResult, exp);
        end
        checks++;
        if (bus.Zero !== (exp == '0)) begin
            errors++;
            $display("FAIL %s zero: got %b, required %b", name, bus.Zero, (exp == '0));
        end
        if (stall > 0) begin
            held_ok = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                if (!(bus.out_valid === 1'b1 && bus.ALUResult === exp && bus.in_ready === 1'b0))
                    held_ok = 1'b0;
            end
            checks++;
            if (!held_ok) begin
                errors++;
                $display("FAIL %s hold: valid=%b result=%h ready=%b, required 1/%h/0",
                         name, bus.out_valid, bus.ALUResult, bus.in_ready, exp);
            end
            bus.out_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.Operation = 4'b0000;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset in_ready: got %b, required 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset out_valid: got %b, required 0", bus.out_valid);
        end
        checks++;
        if (bus.ALUResult !== '0) begin
            errors++; $display("FAIL reset result: got %h, required 0", bus.ALUResult);
        end
        checks++;
        if (bus.Zero !== 1'b1) begin
            errors++; $display("FAIL reset zero: got %b, required 1", bus.Zero);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL post-reset in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_add_overflow();
        run_op(4'b0100, 32'h7FFF_FFFF, 32'h1, 0, "add_ovf");
        checks++;
        if (bus.ALUResult !== 32'h8000_0000) begin
            errors++; $display("FAIL add_ovf value: got %h, required 80000000", bus.ALUResult);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.out_ready = 1'b1;
        accept_op(4'b0101, 32'd5, 32'd5, "b2b_sub");
        @(negedge clk);
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.ALUResult === '0 && bus.Zero === 1'b1)) begin
            errors++;
            $display("FAIL b2b_sub: valid=%b result=%h zero=%b, required 1/0/1",
                     bus.out_valid, bus.ALUResult, bus.Zero);
        end
        accept_op(4'b1010, 32'hFFFF_FFFF, 32'h1, "b2b_blt");
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.ALUResult === 32'h1 && bus.Zero === 1'b0)) begin
            errors++;
            $display("FAIL b2b_blt: valid=%b result=%h zero=%b, required 1/1/0",
                     bus.out_valid, bus.ALUResult, bus.Zero);
        end
    endtask

    task automatic test_sra31();
        int edges, low;
        @(negedge clk);
        bus.out_ready = 1'b1;
        accept_op(4'b1110, 32'h8000_0000, 32'd31, "sra31");
        wait_result(edges, low);
        checks++;
        if (low != 31) begin
            errors++; $display("FAIL sra31 in_ready low: got %0d cycles, required 31", low);
        end
        checks++;
        if (edges != 32) begin
            errors++; $display("FAIL sra31 latency: got %0d edges, required 32", edges);
        end
        checks++;
        if (bus.ALUResult !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sra31 result: got %h, required ffffffff", bus.ALUResult);
        end
    endtask

    task automatic test_sll0_invalid();
        run_op(4'b1100, 32'h1, 32'h0, 0, "sll0");
        checks++;
        if (bus.ALUResult !== 32'h1) begin
            errors++; $display("FAIL sll0 value: got %h, required 1", bus.ALUResult);
        end
        run_op(4'b0111, 32'h1234_5678, 32'h9ABC_DEF0, 0, "op0111");
        checks++;
        if (bus.ALUResult !== '0) begin
            errors++; $display("FAIL op0111 value: got %h, required 0", bus.ALUResult);
        end
    endtask

    task automatic test_backpressure();
        logic ok = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        accept_op(4'b0010, 32'hF0, 32'hFF, "bp_xor");
        repeat (4) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.Operation = 4'b0100;
            bus.SrcA      = $urandom;
            bus.SrcB      = $urandom;
            #1;
            if (!(bus.out_valid === 1'b1 && bus.ALUResult === 32'h0F && bus.in_ready === 1'b0))
                ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_hold: valid=%b result=%h ready=%b, required 1/0000000f/0",
                     bus.out_valid, bus.ALUResult, bus.in_ready);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (!(bus.out_valid === 1'b0 && bus.ALUResult === 32'h0F && bus.Zero === 1'b0)) begin
            errors++;
            $display("FAIL bp_drain: valid=%b result=%h zero=%b, required 0/0000000f/0",
                     bus.out_valid, bus.ALUResult, bus.Zero);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        accept_op(4'b1101, 32'hFFFF_0000, 32'd16, "rst_srl");
        repeat (4) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_srl in_ready in reset: got %b, required 0", bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (!(bus.out_valid === 1'b0 && bus.ALUResult === '0 && bus.Zero === 1'b1 &&
              bus.in_ready === 1'b1)) begin
            errors++;
            $display("FAIL rst_srl after reset: valid=%b result=%h zero=%b ready=%b, required 0/0/1/1",
                     bus.out_valid, bus.ALUResult, bus.Zero, bus.in_ready);
        end
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_srl out_valid: got 1, required 0 throughout");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0]    op;
            logic [DW-1:0] a, b;
            int            stall;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 7) == 0) b[4:0] = 5'd0;
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(op, a, b, stall, $sformatf("rand%0d_op%b", i, op));
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_sra31();
        test_sll0_invalid();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
